// File: rtl/locked_reg_pkg.sv
// Shared types, default widths and helpers for the lockable register bank.
package locked_reg_pkg;

    localparam int unsigned DEF_NUM_REGS   = 4;
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_ADDR_W     = 2;
    localparam int unsigned DEF_VIOL_CNT_W = 8;

    typedef enum logic [1:0] {
        ACCEPT,
        REJECT_LOCK,
        REJECT_ADDR
    } wr_decision_e;

    typedef enum logic {
        LOCK_OPEN,
        LOCK_LOCKED
    } lock_state_e;

    // Increment that holds at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
        return (cnt == max_val) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/locked_reg_cell.sv
// One register plus its sticky lock bit; only reset reopens the lock.
module locked_reg_cell
    import locked_reg_pkg::*;
#(
    parameter int unsigned       DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              lock_set_i,
    input  logic              override_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              locked_o,
    output logic              wr_ok_o
);

    lock_state_e       state_q;
    logic [DATA_W-1:0] data_q;

    // Uses the pre-edge lock state, so a same-cycle lock still lets this write in.
    assign wr_ok_o  = we_i && ((state_q == LOCK_OPEN) || override_i);
    assign data_o   = data_q;
    assign locked_o = (state_q == LOCK_LOCKED);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= RESET_VAL;
            state_q <= LOCK_OPEN;
        end else begin
            if (wr_ok_o) begin
                data_q <= wr_data_i;
            end
            if (lock_set_i) begin
                state_q <= LOCK_LOCKED;
            end
        end
    end

endmodule

// File: rtl/locked_register_bank.sv
// Bank of lockable registers with gated debug override, violation tracking
// and a registered read port.
module locked_register_bank
    import locked_reg_pkg::*;
#(
    parameter int unsigned       NUM_REGS   = DEF_NUM_REGS,
    parameter int unsigned       DATA_W     = DEF_DATA_W,
    parameter int unsigned       ADDR_W     = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0,
    parameter int unsigned       VIOL_CNT_W = DEF_VIOL_CNT_W
) (
    input  logic                  Clk,
    input  logic                  resetn,
    input  logic                  wr_valid,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  lock_valid,
    input  logic [ADDR_W-1:0]     lock_addr,
    input  logic                  lock_all,
    input  logic                  scan_mode,
    input  logic                  debug_unlocked,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic [NUM_REGS-1:0]   lock_status,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  viol_sticky,
    output logic [VIOL_CNT_W-1:0] viol_count
);

    localparam logic [VIOL_CNT_W-1:0] CNT_MAX = '1;

    logic                  override;
    logic [NUM_REGS-1:0]   we_vec;
    logic [NUM_REGS-1:0]   lock_set;
    logic [NUM_REGS-1:0]   wr_ok;
    logic [DATA_W-1:0]     reg_data [NUM_REGS];
    wr_decision_e          decision;

    logic [DATA_W-1:0]     rd_data_d, rd_data_q;
    logic                  wr_ack_d, wr_ack_q;
    logic                  wr_err_d, wr_err_q;
    logic                  viol_sticky_d, viol_sticky_q;
    logic [VIOL_CNT_W-1:0] viol_count_d, viol_count_q;

    assign override = debug_unlocked && !scan_mode;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        assign we_vec[g]   = wr_valid && (wr_addr == ADDR_W'(g));
        assign lock_set[g] = lock_all || (lock_valid && (lock_addr == ADDR_W'(g)));

        locked_reg_cell #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .clk_i      (Clk),
            .rst_ni     (resetn),
            .we_i       (we_vec[g]),
            .lock_set_i (lock_set[g]),
            .override_i (override),
            .wr_data_i  (wr_data),
            .data_o     (reg_data[g]),
            .locked_o   (lock_status[g]),
            .wr_ok_o    (wr_ok[g])
        );
    end

    always_comb begin
        decision = ACCEPT;
        if (32'(wr_addr) >= NUM_REGS) begin
            decision = REJECT_ADDR;
        end else if (!(|wr_ok)) begin
            decision = REJECT_LOCK;
        end
    end

    always_comb begin
        wr_ack_d      = wr_valid && (decision == ACCEPT);
        wr_err_d      = wr_valid && (decision != ACCEPT);
        viol_sticky_d = viol_sticky_q;
        viol_count_d  = viol_count_q;
        if (wr_valid && (decision == REJECT_LOCK)) begin
            viol_sticky_d = 1'b1;
            viol_count_d  = VIOL_CNT_W'(sat_inc(32'(viol_count_q), 32'(CNT_MAX)));
        end
        rd_data_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data_d = reg_data[i];
            end
        end
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            rd_data_q     <= RESET_VAL;
            wr_ack_q      <= 1'b0;
            wr_err_q      <= 1'b0;
            viol_sticky_q <= 1'b0;
            viol_count_q  <= '0;
        end else begin
            rd_data_q     <= rd_data_d;
            wr_ack_q      <= wr_ack_d;
            wr_err_q      <= wr_err_d;
            viol_sticky_q <= viol_sticky_d;
            viol_count_q  <= viol_count_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign wr_ack      = wr_ack_q;
    assign wr_err      = wr_err_q;
    assign viol_sticky = viol_sticky_q;
    assign viol_count  = viol_count_q;

endmodule

// File: tb/tb_locked_register_bank.sv
// Scoreboard bench for locked_register_bank (3 registers in a 2-bit address
// space, 4-bit violation counter).
module tb_locked_register_bank;

    localparam int unsigned NREGS = 3;
    localparam logic [15:0] RV    = 16'h00C3;

    logic        Clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_valid = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        lock_valid = 1'b0;
    logic [1:0]  lock_addr = '0;
    logic        lock_all = 1'b0;
    logic        scan_mode = 1'b0;
    logic        debug_unlocked = 1'b0;
    logic [1:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic [2:0]  lock_status;
    logic        wr_ack, wr_err, viol_sticky;
    logic [3:0]  viol_count;

    locked_register_bank #(
        .NUM_REGS   (NREGS),
        .DATA_W     (16),
        .ADDR_W     (2),
        .RESET_VAL  (RV),
        .VIOL_CNT_W (4)
    ) dut (
        .Clk            (Clk),
        .resetn         (resetn),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .lock_valid     (lock_valid),
        .lock_addr      (lock_addr),
        .lock_all       (lock_all),
        .scan_mode      (scan_mode),
        .debug_unlocked (debug_unlocked),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .lock_status    (lock_status),
        .wr_ack         (wr_ack),
        .wr_err         (wr_err),
        .viol_sticky    (viol_sticky),
        .viol_count     (viol_count)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        sticky;
        logic [3:0]  cnt;
        logic [2:0]  lock;
        logic [15:0] rd;
    } obs_t;

    typedef struct {
        bit          wv;
        int          wa;
        logic [15:0] wd;
        bit          lv;
        int          la;
        bit          lall;
        bit          dbg;
        bit          scan;
        int          ra;
    } op_t;

    obs_t        sb[$];
    logic [15:0] m_reg [NREGS];
    bit          m_lock [NREGS];
    int          m_cnt;
    bit          m_sticky;
    int          checks = 0;
    int          errors = 0;

    function automatic op_t mk(bit wv, int wa, logic [15:0] wd, bit lv, int la,
                               bit lall, bit dbg, bit scan, int ra);
        op_t o;
        o.wv = wv; o.wa = wa; o.wd = wd; o.lv = lv; o.la = la;
        o.lall = lall; o.dbg = dbg; o.scan = scan; o.ra = ra;
        return o;
    endfunction

    function automatic obs_t observed();
        return obs_t'({wr_ack, wr_err, viol_sticky, viol_count, lock_status, rd_data});
    endfunction

    function automatic void reset_model();
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = RV;
            m_lock[i] = 1'b0;
        end
        m_cnt    = 0;
        m_sticky = 1'b0;
    endfunction

    function automatic logic [2:0] model_locks();
        logic [2:0] l;
        for (int i = 0; i < NREGS; i++) l[i] = m_lock[i];
        return l;
    endfunction

    task automatic drive_idle();
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        lock_valid = 1'b0; lock_addr = '0; lock_all = 1'b0;
        scan_mode = 1'b0; debug_unlocked = 1'b0; rd_addr = '0;
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, push the prediction.
    task automatic step(input op_t op);
        obs_t e;
        bit   ovr;
        @(negedge Clk);
        wr_valid = op.wv; wr_addr = 2'(op.wa); wr_data = op.wd;
        lock_valid = op.lv; lock_addr = 2'(op.la); lock_all = op.lall;
        debug_unlocked = op.dbg; scan_mode = op.scan; rd_addr = 2'(op.ra);
        ovr   = op.dbg && !op.scan;
        e     = '0;
        e.rd  = (op.ra < NREGS) ? m_reg[op.ra] : 16'h0000;
        if (op.wv) begin
            if (op.wa >= NREGS) begin
                e.err = 1'b1;
            end else if (!m_lock[op.wa] || ovr) begin
                e.ack = 1'b1;
                m_reg[op.wa] = op.wd;
            end else begin
                e.err    = 1'b1;
                m_sticky = 1'b1;
                if (m_cnt < 15) m_cnt++;
            end
        end
        if (op.lall) begin
            for (int i = 0; i < NREGS; i++) m_lock[i] = 1'b1;
        end
        if (op.lv && op.la < NREGS) m_lock[op.la] = 1'b1;
        e.lock   = model_locks();
        e.cnt    = 4'(m_cnt);
        e.sticky = m_sticky;
        sb.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        op_t  ops[$];
        obs_t e;
        drive_idle();
        resetn = 1'b0;
        reset_model();
        #23;
        checks++;
        if (observed() !== obs_t'({3'b000, 4'h0, 3'b000, RV})) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", observed(), obs_t'({3'b000, 4'h0, 3'b000, RV}));
        end
        @(negedge Clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) ops.push_back(mk(0, 0, 16'h0, 0, 0, 0, 0, 0, i));
        foreach (ops[k]) begin
            step(ops[k]);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL reset_read[%0d]: got %h expected %h", k, observed(), e);
            end
        end
        // Reset asserted just before an edge that carries a write.
        @(negedge Clk);
        wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 16'hDEAD;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (observed() !== obs_t'({3'b000, 4'h0, 3'b000, RV})) begin
            errors++;
            $display("FAIL reset_midwrite_async: got %h expected %h", observed(), obs_t'({3'b000, 4'h0, 3'b000, RV}));
        end
        @(negedge Clk);
        drive_idle();
        resetn = 1'b1;
        reset_model();
        step(mk(0, 0, 16'h0, 0, 0, 0, 0, 0, 0));
        e = sb.pop_front();
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL reset_midwrite_read: got %h expected %h", observed(), e);
        end
    endtask

    task automatic test_lock_basic();
        op_t  ops[$];
        obs_t e;
        ops.push_back(mk(1, 1, 16'hA5A5, 0, 0, 0, 0, 0, 0));
        ops.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 0, 0, 1));
        ops.push_back(mk(1, 1, 16'h1234, 0, 0, 0, 0, 0, 1));
        ops.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 1));
        foreach (ops[k]) begin
            step(ops[k]);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL lock_basic[%0d]: got %h expected %h", k, observed(), e);
            end
        end
    endtask

    task automatic test_same_cycle();
        op_t  ops[$];
        obs_t e;
        ops.push_back(mk(1, 2, 16'hBEEF, 1, 2, 0, 0, 0, 2));
        ops.push_back(mk(1, 2, 16'h1111, 0, 0, 0, 0, 0, 2));
        ops.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 2));
        foreach (ops[k]) begin
            step(ops[k]);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL same_cycle[%0d]: got %h expected %h", k, observed(), e);
            end
        end
    endtask

    task automatic test_addr_range();
        op_t  ops[$];
        obs_t e;
        ops.push_back(mk(1, 3, 16'h7777, 0, 0, 0, 0, 0, 3));
        ops.push_back(mk(0, 0, 16'h0000, 1, 3, 0, 0, 0, 0));
        ops.push_back(mk(1, 0, 16'h2222, 0, 0, 0, 0, 0, 3));
        ops.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0));
        foreach (ops[k]) begin
            step(ops[k]);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL addr_range[%0d]: got %h expected %h", k, observed(), e);
            end
        end
    endtask

    task automatic test_override();
        op_t  ops[$];
        obs_t e;
        ops.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 0, 0, 0));
        ops.push_back(mk(1, 0, 16'h0F0F, 0, 0, 0, 1, 0, 0));
        ops.push_back(mk(1, 0, 16'hF0F0, 0, 0, 0, 1, 1, 0));
        ops.push_back(mk(1, 1, 16'h3333, 0, 0, 0, 0, 0, 0));
        ops.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0));
        foreach (ops[k]) begin
            step(ops[k]);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL override[%0d]: got %h expected %h", k, observed(), e);
            end
        end
    endtask

    task automatic test_saturation();
        op_t  ops[$];
        obs_t e;
        for (int i = 0; i < 20; i++) ops.push_back(mk(1, i % 3, 16'(i), 0, 0, 0, 0, 0, i % 4));
        foreach (ops[k]) begin
            step(ops[k]);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL saturation[%0d]: got %h expected %h", k, observed(), e);
            end
        end
        @(negedge Clk);
        drive_idle();
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (observed() !== obs_t'({3'b000, 4'h0, 3'b000, RV})) begin
            errors++;
            $display("FAIL saturation_reset: got %h expected %h", observed(), obs_t'({3'b000, 4'h0, 3'b000, RV}));
        end
        @(negedge Clk);
        resetn = 1'b1;
        reset_model();
        step(mk(1, 1, 16'h4444, 0, 0, 0, 0, 0, 1));
        e = sb.pop_front();
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL post_reset_open: got %h expected %h", observed(), e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lock_basic();
        test_same_cycle();
        test_addr_range();
        test_override();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
